// File: rtl/detect_run_logger_if.sv
// Read-side port bundle for detect_run_logger.
// The slave modport is the logger itself. The master modport is the consumer that drains the FIFO.
interface detect_run_logger_if #(
  parameter int CNT_W = 8
);
  logic             RD_EN;
  logic             RD_VALID;
  logic [CNT_W-1:0] RD_DATA;
  logic             FULL;

  modport master (
    output RD_EN,
    input  RD_VALID,
    input  RD_DATA,
    input  FULL
  );

  modport slave (
    input  RD_EN,
    output RD_VALID,
    output RD_DATA,
    output FULL
  );
endinterface

// File: rtl/detect_run_logger.sv
// detect_run_logger
//
// Watches the sequence-detector level Y_IN and counts run starts in EVT_CNT.
// It measures the length of each high run and queues the finished lengths in
// a first-word-fall-through FIFO. The FIFO is drained through the rd interface.
// OVERFLOW is sticky. It sets when a finished run is dropped because the FIFO is full.
//
// Build option: define DRL_SATURATE_EN to make the run counter saturate at
// 2^CNT_W-1. When it is undefined, the counter wraps modulo 2^CNT_W.
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | Y_IN low, waiting for a run to start
// S_RUN  | run in progress, run_cnt_q = edges seen high
module detect_run_logger #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  parameter int EVT_W = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Y_IN,
  detect_run_logger_if.slave  rd,
  output logic [EVT_W-1:0]    EVT_CNT,
  output logic                OVERFLOW
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [CNT_W-1:0] run_cnt_d;
  logic [EVT_W-1:0] evt_cnt_q;
  logic             overflow_q;
  logic             overflow_d;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_q [DEPTH];

  logic             empty;
  logic             full;
  logic             push_req;
  logic             push_ok;
  logic             pop_ok;

  // Choose between the saturating and the wrapping increment of the run counter.
`ifdef DRL_SATURATE_EN
  assign run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_W'(1);
`else
  assign run_cnt_d = run_cnt_q + CNT_W'(1);
`endif

  // Decode FIFO status from the registered pointers.
  // When the MSBs differ and the index bits match, the FIFO has wrapped and is full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A run ends when Y_IN is first sampled low while in S_RUN.
  // When the FIFO is full, a pop on the same edge makes room first.
  // A pop is only honoured while an entry is visible.
  always_comb begin
    push_req   = (state_q == S_RUN) && !Y_IN;
    pop_ok     = rd.RD_EN && !empty;
    push_ok    = push_req && (!full || pop_ok);
    overflow_d = overflow_q | (push_req && full && !pop_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Run-tracking FSM: measure the run length and count run starts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      run_cnt_q <= '0;
      evt_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Y_IN) begin
            state_q   <= S_RUN;
            run_cnt_q <= CNT_W'(1);
            evt_cnt_q <= evt_cnt_q + EVT_W'(1);
          end
        end
        S_RUN: begin
          if (Y_IN) begin
            run_cnt_q <= run_cnt_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Update the FIFO pointers and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Write storage. Its contents only matter behind valid pointers, so it has no reset.
  always_ff @(posedge CLK) begin
    if (!RST && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= run_cnt_q;
    end
  end

  assign rd.RD_VALID = !empty;
  assign rd.RD_DATA  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign rd.FULL     = full;
  assign EVT_CNT     = evt_cnt_q;
  assign OVERFLOW    = overflow_q;

endmodule
